// File: rtl/rca_result_collector.sv
// rca_result_collector
// Pairs each grid output-slot result with the instruction ID and destination
// register recorded at issue, strictly in issue order, and presents one
// completed result at a time to writeback over a done/ack handshake.
// IDs and results are buffered in two independent FIFOs because the grid
// completes results at a rate unrelated to issue.
module rca_result_collector #(
   parameter int XLEN  = 32,
   parameter int ID_W  = 3,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     issue_valid,
   input  logic [ID_W-1:0]          issue_id,
   input  logic [4:0]               issue_rd,
   output logic                     issue_ready,
   input  logic [XLEN-1:0]          slot_data,
   input  logic                     slot_valid,
   output logic                     wb_done,
   output logic [ID_W-1:0]          wb_id,
   output logic [4:0]               wb_rd,
   output logic [XLEN-1:0]          wb_data,
   input  logic                     wb_ack,
   output logic [$clog2(DEPTH):0]   inflight,
   output logic                     overflow_err
);

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   localparam int PW = ID_W + 1;
   // ID FIFO entry is {id, rd}.
   localparam int EW = ID_W + 5;
   localparam logic [PW-1:0] PTR_ONE = PW'(1);

   logic [EW-1:0]   id_mem  [DEPTH];
   logic [XLEN-1:0] res_mem [DEPTH];

   logic [PW-1:0]   id_wptr;
   logic [PW-1:0]   id_rptr;
   logic [PW-1:0]   res_wptr;
   logic [PW-1:0]   res_rptr;

   logic            id_full;
   logic            id_empty;
   logic            res_full;
   logic            res_empty;
   logic            id_push;
   logic            res_push;
   logic            load;
   logic [EW-1:0]   id_head;
   logic [XLEN-1:0] res_head;

   assign id_empty  = (id_wptr == id_rptr);
   assign id_full   = (id_wptr[ID_W] != id_rptr[ID_W]) &&
                      (id_wptr[ID_W-1:0] == id_rptr[ID_W-1:0]);
   assign res_empty = (res_wptr == res_rptr);
   assign res_full  = (res_wptr[ID_W] != res_rptr[ID_W]) &&
                      (res_wptr[ID_W-1:0] == res_rptr[ID_W-1:0]);

   // Fullness is judged on the current occupancy only; a pop in the same
   // cycle does not make room for a push. Flush discards same-cycle pushes.
   assign id_push  = issue_valid && !id_full  && !flush;
   assign res_push = slot_valid  && !res_full && !flush;

   // A pair is formed when both heads exist and the output register is free
   // or being consumed this cycle.
   assign load = !id_empty && !res_empty && (!wb_done || wb_ack) && !flush;

   assign id_head  = id_mem[id_rptr[ID_W-1:0]];
   assign res_head = res_mem[res_rptr[ID_W-1:0]];

   assign issue_ready = !id_full;
   assign inflight    = id_wptr - id_rptr;

   // ID FIFO storage write port.
   always_ff @(posedge clk) begin
      if (id_push) begin
         id_mem[id_wptr[ID_W-1:0]] <= {issue_id, issue_rd};
      end
   end

   // Result FIFO storage write port.
   always_ff @(posedge clk) begin
      if (res_push) begin
         res_mem[res_wptr[ID_W-1:0]] <= slot_data;
      end
   end

   // FIFO pointers: pushes advance write pointers, a load pops both heads.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         id_wptr  <= '0;
         id_rptr  <= '0;
         res_wptr <= '0;
         res_rptr <= '0;
      end else if (flush) begin
         id_wptr  <= '0;
         id_rptr  <= '0;
         res_wptr <= '0;
         res_rptr <= '0;
      end else begin
         if (id_push) begin
            id_wptr <= id_wptr + PTR_ONE;
         end
         if (res_push) begin
            res_wptr <= res_wptr + PTR_ONE;
         end
         if (load) begin
            id_rptr  <= id_rptr + PTR_ONE;
            res_rptr <= res_rptr + PTR_ONE;
         end
      end
   end

   // Output register: load a new pair, or retire the presented one on ack.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_done <= 1'b0;
         wb_id   <= '0;
         wb_rd   <= '0;
         wb_data <= '0;
      end else if (flush) begin
         wb_done <= 1'b0;
      end else if (load) begin
         wb_done <= 1'b1;
         wb_id   <= id_head[EW-1:5];
         wb_rd   <= id_head[4:0];
         wb_data <= res_head;
      end else if (wb_ack) begin
         wb_done <= 1'b0;
      end
   end

   // Sticky error for any push dropped because its FIFO was full.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow_err <= 1'b0;
      end else if (!flush && ((issue_valid && id_full) || (slot_valid && res_full))) begin
         overflow_err <= 1'b1;
      end
   end

endmodule
